sar_search_ctrl: RTL and testbench
==================================

// Module: sar_search_ctrl
// PURPOSE
//   Successive-approximation search controller: drives a trial value into an external
//   magnitude comparator (target vs trial) and consumes its gt/eq/lt flags to find the target
//   value, one bit per cycle, MSB first. Sits on the driving side of a comparator interface;
//   used to digitise/locate an unknown value that is only observable through comparisons.
// PARAMETERS
//   WIDTH  4  bit width of trial value, accumulator and result (>=2)
// PORTS
//   clk     in   1      rising-edge clock; one clock domain
//   rst_n   in   1      reset, synchronous, active-low
//   start   in   1      request a new search; accepted only in IDLE
//   cmp_gt  in   1      comparator flag: target > trial (combinational from trial)
//   cmp_eq  in   1      comparator flag: target == trial
//   cmp_lt  in   1      comparator flag: target < trial
//   trial   out  WIDTH  registered value presented to comparator
//   busy    out  1      high in SEARCH and CHECK
//   done    out  1      one-cycle pulse, high while in DONE
//   result  out  WIDTH  search result; held from DONE until next accepted start
//   found   out  1      result confirmed by cmp_eq; held like result
//   err     out  1      comparator flags not one-hot during search; held like result
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE; trial, result, acc, idx=0; busy, done, found, err=0.
//   Reset mid-search aborts immediately to IDLE; no done pulse.
//   States: IDLE, SEARCH, CHECK, DONE. Flags are sampled each edge in SEARCH/CHECK and refer
//   to the trial value present during that cycle.
//   IDLE: start=1 -> SEARCH; acc=0, idx=WIDTH-1, trial=1<<(WIDTH-1); clear found, err.
//   SEARCH (flags one-hot):
//     cmp_eq -> DONE; result=trial, found=1.
//     cmp_gt -> acc'=acc|(1<<idx); cmp_lt -> acc'=acc.
//     idx==0 -> CHECK, trial=acc'; else idx-=1, trial=acc'|(1<<(idx-1)).
//   CHECK: result=acc; found=cmp_eq; -> DONE. (Only target 0 reaches CHECK with a correct comparator.)
//   Flags not exactly one-hot in SEARCH or CHECK -> DONE; err=1, found=0, result=acc.
//   DONE: done=1 for exactly one cycle -> IDLE. trial holds its last value.
//   start ignored in SEARCH, CHECK and DONE. start held high in IDLE re-launches the following
//   cycle; result, found and err are cleared on that launch.
//   Latency (start edge = cycle 0): SEARCH starts at cycle 1; eq on k-th trial -> done at cycle k+1.
//   Max latency is WIDTH+2 cycles (CHECK path).
//   Arithmetic: pure bit set/keep on acc; no carries; all values unsigned WIDTH bits.
// TESTING (bench models comparator combinationally: hidden target vs trial; WIDTH=4)
//   target=5, start@0 -> trials 8,4,6,5; done@5; result=5 found=1 err=0
//   target=0 -> trials 8,4,2,1, CHECK trial 0; done@6; result=0 found=1
//   target=15 -> trials 8,12,14,15; done@5; result=15 found=1; target=8 -> done@2
//   faulty flags 000 on 2nd trial (target=5) -> done@3, err=1, found=0, result=0
//   rst_n=0 during SEARCH cycle 2 -> next cycle IDLE, all outputs 0, no done; new start works
//   start pulsed in SEARCH and DONE -> ignored; sequence and result unchanged

Source files
------------

// File: rtl/sar_search_ctrl_if.sv
// Interface between the successive-approximation controller and its comparator-side user.
// The master side is the controller: it drives trial/status and consumes start and the flags.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output trial, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: presents trial values MSB first to an external
// comparator and resolves the hidden target one bit per cycle.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sar_search_ctrl_if.master     bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0]  IDX_MSB = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IDXW-1:0]  idx;

    logic             one_hot;
    logic [WIDTH-1:0] bit_cur;
    logic [WIDTH-1:0] bit_nxt;
    logic [WIDTH-1:0] acc_next;

    // A flag set that is not exactly one-hot means the comparator cannot be trusted.
    assign one_hot  = (bus.cmp_gt & ~bus.cmp_eq & ~bus.cmp_lt) |
                      (~bus.cmp_gt & bus.cmp_eq & ~bus.cmp_lt) |
                      (~bus.cmp_gt & ~bus.cmp_eq & bus.cmp_lt);
    assign bit_cur  = ONE << idx;
    assign bit_nxt  = ONE << (idx - 1'b1);
    assign acc_next = bus.cmp_gt ? (acc | bit_cur) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            bus.trial  <= '0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.found  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state      <= SEARCH;
                        acc        <= '0;
                        idx        <= IDX_MSB;
                        bus.trial  <= ONE << IDX_MSB;
                        bus.result <= '0;
                        bus.found  <= 1'b0;
                        bus.err    <= 1'b0;
                        bus.busy   <= 1'b1;
                    end
                end

                SEARCH: begin
                    if (!one_hot) begin
                        state      <= DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.err    <= 1'b1;
                        bus.found  <= 1'b0;
                        bus.result <= acc;
                    end else if (bus.cmp_eq) begin
                        state      <= DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.found  <= 1'b1;
                        bus.result <= bus.trial;
                    end else begin
                        acc <= acc_next;
                        // After the LSB decision the accumulator itself gets one confirming trial.
                        if (idx == '0) begin
                            state     <= CHECK;
                            bus.trial <= acc_next;
                        end else begin
                            idx       <= idx - 1'b1;
                            bus.trial <= acc_next | bit_nxt;
                        end
                    end
                end

                CHECK: begin
                    state      <= DONE;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.result <= acc;
                    if (one_hot) begin
                        bus.found <= bus.cmp_eq;
                    end else begin
                        bus.found <= 1'b0;
                        bus.err   <= 1'b1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: a combinational comparator model hides the target and
// each search is checked for its trial sequence, done cycle and final status.
module tb_sar_search_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] target;
    logic       fault;
    int         checks;
    int         errors;

    sar_search_ctrl_if #(.WIDTH(4)) bus ();

    sar_search_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Comparator model; fault forces an all-zero flag set.
    assign bus.cmp_gt = !fault && (target > bus.trial);
    assign bus.cmp_eq = !fault && (target == bus.trial);
    assign bus.cmp_lt = !fault && (target < bus.trial);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Launches one search and follows it cycle by cycle; p counts cycles after the start edge.
    task automatic applyStimulus(input string name, input logic [3:0] tgt,
                                 input logic [19:0] exp_trials, input int ntr,
                                 input int exp_done, input logic [3:0] exp_res,
                                 input logic exp_found, input logic exp_err,
                                 input int fault_p, input bit pulse_start);
        int p;
        int ti;
        bit seen;
        @(negedge clk);
        target    = tgt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        p    = 1;
        ti   = 0;
        seen = 0;
        checkOutput({name, "_busy_at_launch"}, bus.busy, 1);
        checkOutput({name, "_result_cleared"}, bus.result, 0);
        checkOutput({name, "_found_cleared"}, bus.found, 0);
        checkOutput({name, "_err_cleared"}, bus.err, 0);
        while (!seen && p <= 20) begin
            if (bus.done) begin
                seen = 1;
                checkOutput({name, "_done_cycle"}, p, exp_done);
                checkOutput({name, "_result"}, bus.result, exp_res);
                checkOutput({name, "_found"}, bus.found, exp_found);
                checkOutput({name, "_err"}, bus.err, exp_err);
                checkOutput({name, "_trial_count"}, ti, ntr);
                checkOutput({name, "_busy_in_done"}, bus.busy, 0);
            end else if (bus.busy) begin
                if (ti < ntr)
                    checkOutput($sformatf("%s_trial%0d", name, ti), bus.trial,
                                exp_trials[ti*4 +: 4]);
                else
                    checkOutput({name, "_extra_trial"}, ti + 1, ntr);
                ti++;
            end
            fault     = (p == fault_p);
            bus.start = pulse_start && (p == 2 || p == exp_done);
            @(negedge clk);
            p++;
        end
        fault     = 1'b0;
        bus.start = 1'b0;
        if (!seen)
            checkOutput({name, "_timeout"}, 0, 1);
        checkOutput({name, "_done_one_cycle"}, bus.done, 0);
        checkOutput({name, "_idle_after"}, bus.busy, 0);
        checkOutput({name, "_result_held"}, bus.result, exp_res);
        checkOutput({name, "_found_held"}, bus.found, exp_found);
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        target    = '0;
        fault     = 1'b0;
        checks    = 0;
        errors    = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_trial", bus.trial, 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_found", bus.found, 0);
        checkOutput("rst_err", bus.err, 0);
        rst_n = 1'b1;

        applyStimulus("t5", 4'd5, {4'd0, 4'd5, 4'd6, 4'd4, 4'd8}, 4, 5, 4'd5, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("t0", 4'd0, {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}, 5, 6, 4'd0, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("t15", 4'd15, {4'd0, 4'd15, 4'd14, 4'd12, 4'd8}, 4, 5, 4'd15, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("t8", 4'd8, {4'd0, 4'd0, 4'd0, 4'd0, 4'd8}, 1, 2, 4'd8, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("fault", 4'd5, {4'd0, 4'd0, 4'd0, 4'd4, 4'd8}, 2, 3, 4'd0, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus("pulse", 4'd5, {4'd0, 4'd5, 4'd6, 4'd4, 4'd8}, 4, 5, 4'd5, 1'b1, 1'b0, 0, 1'b1);

        // Abort a search with reset in its second cycle.
        @(negedge clk);
        target    = 4'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("abort_trial_before", bus.trial, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_trial", bus.trial, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_result", bus.result, 0);
        checkOutput("abort_found", bus.found, 0);
        checkOutput("abort_err", bus.err, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", bus.done, 0);
        end

        applyStimulus("after_rst", 4'd15, {4'd0, 4'd15, 4'd14, 4'd12, 4'd8}, 4, 5, 4'd15, 1'b1, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
